// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//   Payout side of the vending datapath. Accepts one settlement request
//   (optional can release plus change in 10-yen units), pulses the can gate,
//   then pays the change greedily one coin at a time through the 100/50/10-yen
//   hoppers. Each coin line is held until the hopper acknowledges it. The
//   block reports completion with a done pulse, or a hopper fault with a
//   sticky err flag.
//
//   Optional build macro: HOPPER_EMPTY_EN
//     Adds hop_empty[2:0] (bit2=100, bit1=50, bit0=10 yen). Empty hoppers are
//     skipped when choosing the next coin. If change is still owed and no
//     usable coin remains, the block faults.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active low
//   req        settlement request, accepted when req && ready
//   req_amt    change amount, 10-yen units
//   req_can    release one can for this request
//   hop_empty  per-hopper empty flags (HOPPER_EMPTY_EN builds only)
//   ready      high only while idle
//   can_out    one-cycle can-gate pulse
//   coin_a0    100-yen hopper drive, held until coin_ack
//   coin_50    50-yen hopper drive, held until coin_ack
//   coin_10    10-yen hopper drive, held until coin_ack
//   coin_ack   hopper reports the current coin delivered
//   remain     change still owed, 10-yen units
//   done       one-cycle pulse when settlement completes
//   err        sticky hopper-fault flag, cleared only by reset
// ---------------------------------------------------------------------------
module change_dispenser #(
  parameter int AMT_W       = 5,
  parameter int GAP         = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_can,
`ifdef HOPPER_EMPTY_EN
  input  logic [2:0]       hop_empty,
`endif
  output logic             ready,
  output logic             can_out,
  output logic             coin_a0,
  output logic             coin_50,
  output logic             coin_10,
  input  logic             coin_ack,
  output logic [AMT_W-1:0] remain,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAN, S_SEL, S_COIN, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [AMT_W-1:0] V100 = AMT_W'(10);
  localparam logic [AMT_W-1:0] V50  = AMT_W'(5);
  localparam logic [AMT_W-1:0] V10  = AMT_W'(1);
  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             can_pend_q, can_pend_d;
  logic [2:0]       sel_q, sel_d;     // one-hot {100, 50, 10}
  logic [7:0]       cnt_q, cnt_d;     // ack timeout in COIN, gap count in WAIT
  logic [2:0]       coin_q, coin_d;
  logic             can_out_q, can_out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [2:0]       avail;
  logic [AMT_W-1:0] coin_val;

`ifdef HOPPER_EMPTY_EN
  assign avail = ~hop_empty;
`else
  assign avail = 3'b111;
`endif

  always_comb begin
    coin_val = V10;
    unique case (sel_q)
      3'b100:  coin_val = V100;
      3'b010:  coin_val = V50;
      default: coin_val = V10;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    can_pend_d = can_pend_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rem_d      = req_amt;
          can_pend_d = req_can;
          state_d    = S_CAN;
        end
      end
      S_CAN: state_d = S_SEL;
      S_SEL: begin
        cnt_d = 8'd0;
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (avail[2] && rem_q >= V100) begin
          sel_d   = 3'b100;
          state_d = S_COIN;
        end else if (avail[1] && rem_q >= V50) begin
          sel_d   = 3'b010;
          state_d = S_COIN;
        end else if (avail[0]) begin
          sel_d   = 3'b001;
          state_d = S_COIN;
        end else begin
          // Change owed but every fitting hopper is empty.
          state_d = S_ERR;
        end
      end
      S_COIN: begin
        // An ack on the final allowed cycle still counts as delivered.
        if (coin_ack) begin
          rem_d   = rem_q - coin_val;
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == GAP_LAST) state_d = S_SEL;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    coin_d    = (state_d == S_COIN) ? sel_d : 3'b000;
    can_out_d = (state_d == S_CAN) && can_pend_d;
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      can_pend_q <= 1'b0;
      sel_q      <= 3'b000;
      cnt_q      <= 8'd0;
      coin_q     <= 3'b000;
      can_out_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      can_pend_q <= can_pend_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      coin_q     <= coin_d;
      can_out_q  <= can_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign can_out = can_out_q;
  assign coin_a0 = coin_q[2];
  assign coin_50 = coin_q[1];
  assign coin_10 = coin_q[0];
  assign remain  = rem_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//   Table-driven bench for change_dispenser acting as the hopper: it acks each
//   coin line a set number of cycles after it rises (or never). Each vector
//   records the coin order, remain at each coin start, pulse counts and the
//   longest line-high run, then compares them to hand-computed values.
//   Hand-written sequences cover first-coin latency, busy requests, and
//   reset in the middle of a payout.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int AMT_W = 5;
  localparam int GAP   = 2;
  localparam int TO    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic [AMT_W-1:0] req_amt;
  logic             req_can;
  logic [2:0]       hop_empty;
  logic             ready, can_out, coin_a0, coin_50, coin_10, coin_ack;
  logic [AMT_W-1:0] remain;
  logic             done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(AMT_W), .GAP(GAP), .ACK_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_amt  (req_amt),
    .req_can  (req_can),
`ifdef HOPPER_EMPTY_EN
    .hop_empty(hop_empty),
`endif
    .ready    (ready),
    .can_out  (can_out),
    .coin_a0  (coin_a0),
    .coin_50  (coin_50),
    .coin_10  (coin_10),
    .coin_ack (coin_ack),
    .remain   (remain),
    .done     (done),
    .err      (err)
  );

  // Coin codes in exp_seq: 1 = 100 yen, 2 = 50 yen, 3 = 10 yen (one nibble each).
  // exp_rems: remain at the start of each coin, one byte each.
  typedef struct {
    logic [AMT_W-1:0] amt;
    logic             can;
    logic [2:0]       hop;
    int               ack_dly;   // 0 = never ack
    logic [31:0]      exp_seq;
    int               exp_n;
    logic [63:0]      exp_rems;
    int               exp_can;
    int               exp_done;
    logic             exp_err;
    logic [AMT_W-1:0] exp_rem;
    int               exp_hi;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " ready"}, 64'(ready), 64'd1);
    chk({tag, " outs"}, 64'({can_out, coin_a0, coin_50, coin_10, done, err}), 64'd0);
    chk({tag, " remain"}, 64'(remain), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req = 1'b0; coin_ack = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [2:0]  lines, prev;
    logic [31:0] seq;
    logic [63:0] rems;
    int n, can_c, done_c, hi_run, max_hi, low_run, min_gap, cyc, post;
    bit multi, seen_end, err_drop;
    string tag;
    tag = $sformatf("vec%0d", idx);
    apply_reset();
    hop_empty = v.hop;
    req = 1'b1; req_amt = v.amt; req_can = v.can;
    @(negedge clk);
    req = 1'b0;
    prev = 3'b000; seq = 0; rems = 0; n = 0; can_c = 0; done_c = 0;
    hi_run = 0; max_hi = 0; low_run = 0; min_gap = 255; cyc = 0; post = 0;
    multi = 0; seen_end = 0; err_drop = 0;
    while (cyc < 1000 && post < 20) begin
      lines = {coin_a0, coin_50, coin_10};
      if ($countones(lines) > 1) multi = 1;
      if (lines != 3'b000 && prev == 3'b000) begin
        if (n > 0 && low_run < min_gap) min_gap = low_run;
        seq  = (seq << 4) | (lines[2] ? 32'd1 : lines[1] ? 32'd2 : 32'd3);
        rems = (rems << 8) | 64'(remain);
        n++;
        low_run = 0;
      end
      if (lines != 3'b000) begin
        hi_run++;
      end else begin
        if (hi_run > max_hi) max_hi = hi_run;
        hi_run = 0;
        low_run++;
      end
      can_c  += int'(can_out);
      done_c += int'(done);
      if (seen_end && v.exp_err && (!err || lines != 3'b000 || remain != v.exp_rem))
        err_drop = 1;
      if (done || err) seen_end = 1;
      if (seen_end) post++;
      coin_ack = (lines != 3'b000) && (v.ack_dly != 0) && (hi_run >= v.ack_dly);
      prev = lines;
      cyc++;
      @(negedge clk);
    end
    coin_ack = 1'b0;
    chk({tag, " finished"}, 64'(seen_end), 64'd1);
    chk({tag, " coin order"}, 64'(seq), 64'(v.exp_seq));
    chk({tag, " coin count"}, 64'(n), 64'(v.exp_n));
    chk({tag, " remain at coins"}, rems, v.exp_rems);
    chk({tag, " can pulses"}, 64'(can_c), 64'(v.exp_can));
    chk({tag, " done pulses"}, 64'(done_c), 64'(v.exp_done));
    chk({tag, " err"}, 64'(err), 64'(v.exp_err));
    chk({tag, " final remain"}, 64'(remain), 64'(v.exp_rem));
    chk({tag, " line high run"}, 64'(max_hi), 64'(v.exp_hi));
    chk({tag, " one-hot lines"}, 64'(multi), 64'd0);
    chk({tag, " ready at end"}, 64'(ready), 64'(!v.exp_err));
    if (v.exp_err) chk({tag, " err sticky"}, 64'(err_drop), 64'd0);
    if (v.exp_n > 1) chk({tag, " gap ok"}, 64'(min_gap >= GAP), 64'd1);
    $display("%s amt=%0d can=%0d coins=%0d seq=%0h done=%0d err=%0d remain=%0d",
             tag, v.amt, v.can, n, seq, done_c, err, remain);
  endtask

  vec_t vecs[8];
  int   nvec;

  initial begin
    int k;
    rst = 1'b0; req = 1'b0; req_amt = '0; req_can = 1'b0;
    coin_ack = 1'b0; hop_empty = 3'b000;

    //          amt can hop  dly seq          n  rems                     can done err rem hi
    vecs[0] = '{5'd13, 1'b1, 3'b000, 1,  32'h1333,    4, 64'h0D030201,           1, 1, 1'b0, 5'd0, 1};
    vecs[1] = '{5'd0,  1'b1, 3'b000, 1,  32'h0,       0, 64'h0,                  1, 1, 1'b0, 5'd0, 0};
    vecs[2] = '{5'd19, 1'b0, 3'b000, 1,  32'h123333,  6, 64'h130904030201,       0, 1, 1'b0, 5'd0, 1};
    vecs[3] = '{5'd31, 1'b0, 3'b000, 3,  32'h1113,    4, 64'h1F150B01,           0, 1, 1'b0, 5'd0, 3};
    vecs[4] = '{5'd5,  1'b1, 3'b000, 14, 32'h2,       1, 64'h05,                 1, 1, 1'b0, 5'd0, 14};
    vecs[5] = '{5'd5,  1'b0, 3'b000, 0,  32'h2,       1, 64'h05,                 0, 0, 1'b1, 5'd5, 15};
    nvec = 6;
`ifdef HOPPER_EMPTY_EN
    vecs[6] = '{5'd12, 1'b0, 3'b100, 1,  32'h2233,    4, 64'h0C070201,           0, 1, 1'b0, 5'd0, 1};
    vecs[7] = '{5'd3,  1'b0, 3'b011, 1,  32'h0,       0, 64'h0,                  0, 0, 1'b1, 5'd3, 0};
    nvec = 8;
`endif

    for (int i = 0; i < nvec; i++) run_vec(i, vecs[i]);

    // First-coin latency, busy requests ignored, reset during second coin.
    hop_empty = 3'b000;
    apply_reset();
    req = 1'b1; req_amt = 5'd20; req_can = 1'b0;
    @(negedge clk);                      // CAN
    req_amt = 5'd1;                      // held req while busy must be ignored
    chk("lat cyc1 coin low", 64'({coin_a0, coin_50, coin_10}), 64'd0);
    chk("busy ready low", 64'(ready), 64'd0);
    @(negedge clk);                      // SEL
    chk("lat cyc2 coin low", 64'({coin_a0, coin_50, coin_10}), 64'd0);
    @(negedge clk);                      // COIN
    chk("lat cyc3 coin_a0", 64'({coin_a0, coin_50, coin_10}), 64'b100);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    chk("first coin remain", 64'(remain), 64'd10);
    chk("line dropped after ack", 64'({coin_a0, coin_50, coin_10}), 64'd0);
    k = 0;
    while (!coin_a0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("second coin_a0 seen", 64'(coin_a0), 64'd1);
    chk("busy req ignored", 64'(remain), 64'd10);
    req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("mid-payout reset");
    rst = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!ready || coin_a0 || coin_50 || coin_10 || can_out || done) k++;
    end
    chk("abandoned request stays idle", 64'(k), 64'd0);
    $display("reset-mid-payout sequence ready=%0d remain=%0d", ready, remain);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
